// File: rtl/ncl_gray_capture.sv
// ncl_gray_capture: clocked-domain receiver for a dual-rail NCL Gray encoder.
// It synchronizes the rails and detects DATA/NULL completion. It drives the NCL
// acknowledge (ko) back upstream. Captured words are converted from Gray to
// binary and buffered behind a valid/ready handshake. Illegal rail codes and
// stalled wavefronts are reported through sticky error flags.
module ncl_gray_capture #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   in_rails,
    output logic                 ko,
    output logic [WIDTH-1:0]     gray_q,
    output logic [WIDTH-1:0]     bin_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_illegal,
    output logic                 err_timeout,
    input  logic                 err_clr,
    output logic [7:0]           word_cnt
);

    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned SCW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);
    localparam logic [TCW-1:0] TMO_MAX    = TCW'(TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        STABLE    = 2'd1,
        WAIT_NULL = 2'd2
    } state_t;

    state_t           state;
    logic [RW-1:0]    sync_q [SYNC_STAGES];
    logic [RW-1:0]    s;
    logic [RW-1:0]    snap_q;
    logic [SCW-1:0]   stable_cnt;
    logic [TCW-1:0]   tmo_cnt;

    logic [WIDTH-1:0] dig_data_c;
    logic [WIDTH-1:0] dig_ill_c;
    logic [WIDTH-1:0] snap_gray_c;
    logic             complete_c;
    logic             null_c;
    logic             illegal_c;
    logic             partial_c;
    logic             buf_free_c;
    logic             tmo_cond_c;
    logic             tmo_hit_c;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Per-rail flop synchronizer chain; the last stage feeds all classification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_rails;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-digit decode of synchronized rails and of the held snapshot.
    always_comb begin
        dig_data_c  = '0;
        dig_ill_c   = '0;
        snap_gray_c = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            dig_data_c[k]  = s[2*k+1] ^ s[2*k];
            dig_ill_c[k]   = s[2*k+1] & s[2*k];
            snap_gray_c[k] = snap_q[2*k+1];
        end
    end

    // Wavefront classification.
    assign complete_c = &dig_data_c;
    assign null_c     = (s == '0);
    assign illegal_c  = |dig_ill_c;
    assign partial_c  = !complete_c && !null_c && !illegal_c;

    // The output slot can take a new word when empty or being popped this cycle.
    assign buf_free_c = !out_valid || out_ready;

    // Stall conditions: an incomplete DATA wavefront, or a NULL wavefront that never arrives.
    assign tmo_cond_c = ((state == WAIT_DATA) && partial_c) ||
                        ((state == WAIT_NULL) && !null_c);
    assign tmo_hit_c  = tmo_cond_c && (tmo_cnt >= (TMO_MAX - TCW'(1)));

    // Handshake FSM, capture datapath and output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_DATA;
            ko         <= 1'b1;
            snap_q     <= '0;
            stable_cnt <= '0;
            gray_q     <= '0;
            bin_q      <= '0;
            out_valid  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            // A pop empties the slot; a same-edge capture below refills it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                WAIT_DATA: begin
                    ko <= 1'b1;
                    if (complete_c) begin
                        state      <= STABLE;
                        snap_q     <= s;
                        stable_cnt <= SCW'(1);
                    end
                end
                STABLE: begin
                    if ((s != snap_q) || !complete_c) begin
                        // Glitch or illegal code during settling: start over.
                        state      <= WAIT_DATA;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_MAX) begin
                        // When the buffer is full, hold here with ko high so upstream keeps DATA.
                        if (buf_free_c) begin
                            gray_q     <= snap_gray_c;
                            bin_q      <= gray2bin(snap_gray_c);
                            out_valid  <= 1'b1;
                            word_cnt   <= word_cnt + 8'd1;
                            ko         <= 1'b0;
                            state      <= WAIT_NULL;
                            stable_cnt <= '0;
                        end
                    end else begin
                        stable_cnt <= stable_cnt + SCW'(1);
                    end
                end
                WAIT_NULL: begin
                    if (null_c) begin
                        state <= WAIT_DATA;
                        ko    <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_DATA;
                    ko    <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; any break in the stall condition clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (tmo_cond_c) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TCW'(1);
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Sticky error flags; a same-cycle set takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (illegal_c) begin
                err_illegal <= 1'b1;
            end else if (err_clr) begin
                err_illegal <= 1'b0;
            end
            if (tmo_hit_c) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ncl_gray_capture.sv
// Directed bench for ncl_gray_capture with default parameters.
module tb_ncl_gray_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_rails;
    logic       ko;
    logic [3:0] gray_q;
    logic [3:0] bin_q;
    logic       out_valid;
    logic       out_ready;
    logic       err_illegal;
    logic       err_timeout;
    logic       err_clr;
    logic [7:0] word_cnt;

    int checks;
    int errors;

    ncl_gray_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_rails    (in_rails),
        .ko          (ko),
        .gray_q      (gray_q),
        .bin_q       (bin_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_rails  = 8'b10101010;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        step(3);
        checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t1_ko got %0b exp 1", ko); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid got %0b exp 0", out_valid); end
        checks++; if (gray_q !== 4'b0000) begin errors++; $display("FAIL t1_gray got %b exp 0000", gray_q); end
        checks++; if (bin_q !== 4'b0000) begin errors++; $display("FAIL t1_bin got %b exp 0000", bin_q); end
        checks++; if ({err_illegal, err_timeout} !== 2'b00) begin errors++; $display("FAIL t1_errs got %b exp 00", {err_illegal, err_timeout}); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL t1_cnt got %0d exp 0", word_cnt); end
        rst_n    = 1'b1;
        in_rails = 8'b0;
        step(3);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_rails  = 8'b01_10_01_10;
        step(4);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_early_valid got %0b exp 0", out_valid); end
        step(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %0b exp 1", out_valid); end
        checks++; if (gray_q !== 4'b0101) begin errors++; $display("FAIL t2_gray got %b exp 0101", gray_q); end
        checks++; if (bin_q !== 4'b0110) begin errors++; $display("FAIL t2_bin got %b exp 0110", bin_q); end
        checks++; if (ko !== 1'b0) begin errors++; $display("FAIL t2_ko_low got %0b exp 0", ko); end
        in_rails = 8'b0;
        step(2);
        checks++; if (ko !== 1'b0) begin errors++; $display("FAIL t2_ko_early got %0b exp 0", ko); end
        step(1);
        checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t2_ko_high got %0b exp 1", ko); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL t2_cnt got %0d exp 1", word_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_popped got %0b exp 0", out_valid); end
        checks++; if (gray_q !== 4'b0101) begin errors++; $display("FAIL t2_gray_hold got %b exp 0101", gray_q); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_rails  = 8'b10_10_10_10;
        step(5);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_valid1 got %0b exp 1", out_valid); end
        checks++; if (bin_q !== 4'b1010) begin errors++; $display("FAIL t3_bin1 got %b exp 1010", bin_q); end
        in_rails = 8'b0;
        step(3);
        checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t3_null_ko got %0b exp 1", ko); end
        in_rails = 8'b10_01_01_01;
        step(10);
        checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t3_hold_ko got %0b exp 1", ko); end
        checks++; if (gray_q !== 4'b1111) begin errors++; $display("FAIL t3_hold_gray got %b exp 1111", gray_q); end
        checks++; if (word_cnt !== 8'd2) begin errors++; $display("FAIL t3_hold_cnt got %0d exp 2", word_cnt); end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_valid2 got %0b exp 1", out_valid); end
        checks++; if (gray_q !== 4'b1000) begin errors++; $display("FAIL t3_gray2 got %b exp 1000", gray_q); end
        checks++; if (bin_q !== 4'b1111) begin errors++; $display("FAIL t3_bin2 got %b exp 1111", bin_q); end
        checks++; if (ko !== 1'b0) begin errors++; $display("FAIL t3_ko2 got %0b exp 0", ko); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL t3_cnt2 got %0d exp 3", word_cnt); end
        out_ready = 1'b1;
        in_rails  = 8'b0;
        step(4);
        checks++; if ({out_valid, ko} !== 2'b01) begin errors++; $display("FAIL t3_drain got %b exp 01", {out_valid, ko}); end
    endtask

    task automatic test_illegal();
        in_rails = 8'b01_11_01_01;
        step(2);
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL t4_early got %0b exp 0", err_illegal); end
        step(1);
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL t4_set got %0b exp 1", err_illegal); end
        step(5);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_valid got %0b exp 0", out_valid); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL t4_cnt got %0d exp 3", word_cnt); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL t4_set_wins got %0b exp 1", err_illegal); end
        in_rails = 8'b0;
        step(3);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL t4_clr got %0b exp 0", err_illegal); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL t4_tmo got %0b exp 0", err_timeout); end
    endtask

    task automatic test_timeout();
        in_rails = 8'b00_00_00_10;
        step(65);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL t5_early got %0b exp 0", err_timeout); end
        step(1);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL t5_set got %0b exp 1", err_timeout); end
        step(4);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL t5_sticky got %0b exp 1", err_timeout); end
        checks++; if ({out_valid, ko} !== 2'b01) begin errors++; $display("FAIL t5_nocap got %b exp 01", {out_valid, ko}); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL t5_cnt got %0d exp 3", word_cnt); end
        in_rails = 8'b01_01_01_10;
        step(5);
        checks++; if (bin_q !== 4'b0001) begin errors++; $display("FAIL t5_recover got %b exp 0001", bin_q); end
        checks++; if (word_cnt !== 8'd4) begin errors++; $display("FAIL t5_cnt2 got %0d exp 4", word_cnt); end
        in_rails = 8'b0;
        step(3);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL t5_clr got %0b exp 0", err_timeout); end
        checks++; if (word_cnt !== 8'd4) begin errors++; $display("FAIL t5_cnt_clr got %0d exp 4", word_cnt); end
    endtask

    task automatic test_sweep();
        logic [3:0] g;
        logic [7:0] r;
        logic [3:0] iv;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_rails = 8'b0;
        step(2);
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            g  = iv ^ (iv >> 1);
            r  = '0;
            for (int k = 0; k < 4; k++) begin
                r[2*k+1] = g[k];
                r[2*k]   = ~g[k];
            end
            in_rails = r;
            step(5);
            checks++; if ({out_valid, gray_q, bin_q} !== {1'b1, g, iv}) begin
                errors++; $display("FAIL t6_word%0d got v=%0b g=%b b=%b exp v=1 g=%b b=%b", i, out_valid, gray_q, bin_q, g, iv);
            end
            in_rails = 8'b0;
            step(3);
            checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t6_null%0d got %0b exp 1", i, ko); end
        end
        checks++; if (word_cnt !== 8'd16) begin errors++; $display("FAIL t6_cnt got %0d exp 16", word_cnt); end
        out_ready = 1'b0;
        in_rails  = 8'b10_01_10_01;
        step(5);
        checks++; if ({out_valid, ko} !== 2'b10) begin errors++; $display("FAIL t6_pre_rst got %b exp 10", {out_valid, ko}); end
        rst_n = 1'b0;
        #1;
        checks++; if (ko !== 1'b1) begin errors++; $display("FAIL t6_rst_ko got %0b exp 1", ko); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_valid got %0b exp 0", out_valid); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL t6_rst_cnt got %0d exp 0", word_cnt); end
        checks++; if (gray_q !== 4'b0000) begin errors++; $display("FAIL t6_rst_gray got %b exp 0000", gray_q); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
